write_back_stage: RTL and testbench
===================================

# write_back_stage

Final pipeline stage of the vector ASIP, directly downstream of the memory stage. It accepts one instruction at a time from the memory stage and waits for multi-cycle memory accesses to finish, stalling upstream while it waits. It then commits the scalar (8-bit) or vector (20×8-bit) result to the matching register-file write port for exactly one cycle. It also detects memory accesses that never complete and keeps a retired-instruction count.

## Interface
Parameters:
- LANES, 20, vector lanes
- WIDTH, 8, bits per lane / scalar width
- REG_ADDR_W, 4, register index width
- MEM_TIMEOUT, 64, max cycles spent in WAIT_MEM

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  instruction present from memory stage
- op_type  in  1  0 = scalar, 1 = vector
- is_mem  in  1  instruction used the memory stage (load or store)
- reg_write  in  1  instruction writes a register
- rd  in  REG_ADDR_W  destination register
- scalar_output  in  WIDTH  memory-stage scalar result
- vector_output  in  LANES×WIDTH  memory-stage vector result
- mem_finished  in  1  memory stage done with current access
- stall  out  1  upstream must hold its instruction
- we_sca / waddr_sca / wdata_sca  out  1 / REG_ADDR_W / WIDTH  scalar RF write port
- we_vec / waddr_vec / wdata_vec  out  1 / REG_ADDR_W / LANES×WIDTH  vector RF write port
- timeout_err  out  1  sticky, memory access exceeded MEM_TIMEOUT
- retired_count  out  16  committed instructions, wraps at 2^16

## Operation
- States: IDLE, WAIT_MEM, COMMIT. Reset state is IDLE.
- Accept: valid_in is sampled only in IDLE or COMMIT.
  - If !is_mem, or mem_finished is high in the accept cycle: latch control and data, go to COMMIT.
  - Otherwise: latch control, clear the timer, go to WAIT_MEM.
  - No valid_in: go to (or stay in) IDLE.
- WAIT_MEM: timer increments each cycle and valid_in is ignored.
  - mem_finished=1: capture scalar_output/vector_output, go to COMMIT. mem_finished has priority over timeout in the same cycle.
  - Timer reaches MEM_TIMEOUT-1 without mem_finished: set timeout_err, drop the instruction with no write, go to IDLE.
- COMMIT: write and retire the latched instruction.
  - If reg_write && op_type=0 && rd≠0: we_sca=1. Scalar writes to rd 0 are suppressed.
  - If reg_write && op_type=1: we_vec=1. Vector writes to rd 0 are allowed.
  - retired_count increments, including for stores and suppressed writes.
  - Same cycle: a new valid_in is accepted by the IDLE rules (back-to-back).
- Data is registered at capture. The write ports drive latched values and are never a combinational path from the inputs.
- timeout_err stays high until rst.

## Timing
- Reset values: every output 0, timer 0, state IDLE. rst acts immediately and asynchronously in any state.
- Reset mid-WAIT_MEM or mid-COMMIT aborts the instruction: no write, and stall falls asynchronously.
- stall = (state == WAIT_MEM). It is registered only.
  - The cycle after an is_mem accept, stall is high.
  - Upstream presents its next instruction and holds it until stall falls.
- Latency:
  - Non-mem instruction accepted at cycle N: we_* high at N+1.
  - Mem access with mem_finished at cycle M: we_* high at M+1.
- we_sca/we_vec are each high for exactly one cycle per instruction; at most one of the two is high.
- Throughput is one instruction per cycle for non-mem streams.
- Timeout fires at the MEM_TIMEOUT-th WAIT_MEM cycle; timeout_err is high from the next edge.

## Structure
- Package wb_pkg holds:
  - wb_state_e enum (IDLE, WAIT_MEM, COMMIT)
  - LANES and WIDTH constants
  - vec_t = logic [LANES-1:0][WIDTH-1:0]
- Sub-module mem_wait_timer: clear/enable counter of width $clog2(MEM_TIMEOUT) with an expired flag. write_back_stage instantiates it once.

## Test plan
- Reset: rst=1 with random inputs → all outputs 0, stall=0. Release → still idle until valid_in.
- Scalar ALU: valid_in, is_mem=0, op_type=0, reg_write=1, rd=3, scalar_output=40 → next cycle we_sca=1, waddr_sca=3, wdata_sca=40 for one cycle; retired_count=1.
- Vector load: is_mem=1, op_type=1, rd=2, mem_finished after 20 cycles, vector_output lanes 100..119 → stall high 20 cycles; we_vec=1 one cycle later, waddr_vec=2, lanes 100..119.
- Timeout: mem_finished held 0 → timeout_err=1 after 64 WAIT_MEM cycles, no we_*, stall drops, later instructions still commit.
- Back-to-back: three non-mem scalar instructions on consecutive cycles, rd=1,2,0 → we_sca high two consecutive cycles, then the rd 0 write suppressed; retired_count=3.
- Reset mid-WAIT_MEM: rst pulse during the vector load wait → stall=0 immediately, no write even if mem_finished follows.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage of the vector ASIP.
// State encoding, lane geometry and the packed vector type live here.
package wb_pkg;

    localparam int LANES = 20;
    localparam int WIDTH = 8;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Clear/enable cycle counter that flags the last permitted cycle of a memory wait.
// The expired flag is high while the count sits at MEM_TIMEOUT-1.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: waits out multi-cycle memory accesses, then commits the
// latched scalar or vector result to its register-file port for one cycle.
module write_back_stage #(
    parameter int LANES       = wb_pkg::LANES,
    parameter int WIDTH       = wb_pkg::WIDTH,
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic                              op_type,
    input  logic                              is_mem,
    input  logic                              reg_write,
    input  logic [REG_ADDR_W-1:0]             rd,
    input  logic [WIDTH-1:0]                  scalar_output,
    input  logic [LANES-1:0][WIDTH-1:0]       vector_output,
    input  logic                              mem_finished,
    output logic                              stall,
    output logic                              we_sca,
    output logic [REG_ADDR_W-1:0]             waddr_sca,
    output logic [WIDTH-1:0]                  wdata_sca,
    output logic                              we_vec,
    output logic [REG_ADDR_W-1:0]             waddr_vec,
    output logic [LANES-1:0][WIDTH-1:0]       wdata_vec,
    output logic                              timeout_err,
    output logic [15:0]                       retired_count
);

    import wb_pkg::*;

    wb_state_e                   r_state;
    wb_state_e                   w_state_next;
    logic                        r_op_type;
    logic                        r_reg_write;
    logic [REG_ADDR_W-1:0]       r_rd;
    logic [WIDTH-1:0]            r_sdata;
    logic [LANES-1:0][WIDTH-1:0] r_vdata;
    logic                        r_timeout_err;
    logic [15:0]                 r_retired;

    logic w_waiting;
    logic w_accept;
    logic w_direct;
    logic w_to_wait;
    logic w_capture;
    logic w_expired;
    logic w_timeout;

    // A new instruction is only taken when the stage is not blocked on memory.
    assign w_waiting = (r_state == WAIT_MEM);
    assign w_accept  = valid_in && !w_waiting;
    assign w_direct  = w_accept && (!is_mem || mem_finished);
    assign w_to_wait = w_accept && is_mem && !mem_finished;
    assign w_capture = w_direct || (w_waiting && mem_finished);
    assign w_timeout = w_waiting && !mem_finished && w_expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_to_wait),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_direct)       w_state_next = COMMIT;
                else if (w_to_wait) w_state_next = WAIT_MEM;
                else                w_state_next = IDLE;
            end
            WAIT_MEM: begin
                if (mem_finished)   w_state_next = COMMIT;
                else if (w_expired) w_state_next = IDLE;
            end
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_op_type     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_rd          <= '0;
            r_sdata       <= '0;
            r_vdata       <= '0;
            r_timeout_err <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op_type   <= op_type;
                r_reg_write <= reg_write;
                r_rd        <= rd;
            end
            if (w_capture) begin
                r_sdata <= scalar_output;
                r_vdata <= vector_output;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == COMMIT) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    // Scalar register 0 is hardwired; vector register 0 is a real register.
    assign we_sca        = (r_state == COMMIT) && r_reg_write && !r_op_type && (r_rd != '0);
    assign we_vec        = (r_state == COMMIT) && r_reg_write && r_op_type;
    assign waddr_sca     = r_rd;
    assign waddr_vec     = r_rd;
    assign wdata_sca     = r_sdata;
    assign wdata_vec     = r_vdata;
    assign stall         = w_waiting;
    assign timeout_err   = r_timeout_err;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed plus randomized bench for write_back_stage, checked against an
// instruction-level model of commits, retire count and timeout behaviour.
module tb_write_back_stage;

    import wb_pkg::*;

    localparam int MEM_TIMEOUT = 64;

    typedef struct {
        bit         op;
        bit         mem;
        bit         rw;
        logic [3:0] rd;
        logic [7:0] s;
        vec_t       v;
        int         delay;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       op_type;
    logic       is_mem;
    logic       reg_write;
    logic [3:0] rd;
    logic [7:0] scalar_output;
    vec_t       vector_output;
    logic       mem_finished;
    logic       stall;
    logic       we_sca;
    logic [3:0] waddr_sca;
    logic [7:0] wdata_sca;
    logic       we_vec;
    logic [3:0] waddr_vec;
    vec_t       wdata_vec;
    logic       timeout_err;
    logic [15:0] retired_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ret  = 0;
    bit exp_terr = 0;

    write_back_stage #(
        .LANES       (LANES),
        .WIDTH       (WIDTH),
        .REG_ADDR_W  (4),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .op_type       (op_type),
        .is_mem        (is_mem),
        .reg_write     (reg_write),
        .rd            (rd),
        .scalar_output (scalar_output),
        .vector_output (vector_output),
        .mem_finished  (mem_finished),
        .stall         (stall),
        .we_sca        (we_sca),
        .waddr_sca     (waddr_sca),
        .wdata_sca     (wdata_sca),
        .we_vec        (we_vec),
        .waddr_vec     (waddr_vec),
        .wdata_vec     (wdata_vec),
        .timeout_err   (timeout_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int l = 0; l < LANES; l++) v[l] = 8'($urandom);
        return v;
    endfunction

    function automatic instr_t mk(bit op, bit mem, bit rw, logic [3:0] r, int delay);
        instr_t t;
        t.op = op; t.mem = mem; t.rw = rw; t.rd = r; t.delay = delay;
        t.s = 8'($urandom);
        t.v = rand_vec();
        return t;
    endfunction

    task automatic idle_inputs();
        valid_in      = 1'b0;
        op_type       = 1'($urandom);
        is_mem        = 1'($urandom);
        reg_write     = 1'($urandom);
        rd            = 4'($urandom);
        scalar_output = 8'($urandom);
        vector_output = rand_vec();
        mem_finished  = 1'($urandom);
    endtask

    task automatic drive(input instr_t t);
        valid_in  = 1'b1;
        op_type   = t.op;
        is_mem    = t.mem;
        reg_write = t.rw;
        rd        = t.rd;
        if (!t.mem || t.delay == 0) begin
            scalar_output = t.s;
            vector_output = t.v;
            mem_finished  = t.mem ? 1'b1 : 1'($urandom);
        end else begin
            scalar_output = 8'($urandom);
            vector_output = rand_vec();
            mem_finished  = 1'b0;
        end
    endtask

    // Model: a committed instruction writes only by the register-file rules, always retires.
    task automatic check_commit(input instr_t t, input string tag);
        bit es;
        bit ev;
        es = t.rw && !t.op && (t.rd != 4'd0);
        ev = t.rw && t.op;
        chk({tag, ".we_sca"}, we_sca, es);
        chk({tag, ".we_vec"}, we_vec, ev);
        chk({tag, ".stall"}, stall, 0);
        if (es) begin
            chk({tag, ".waddr_sca"}, waddr_sca, t.rd);
            chk({tag, ".wdata_sca"}, wdata_sca, t.s);
        end
        if (ev) begin
            chk({tag, ".waddr_vec"}, waddr_vec, t.rd);
            chk({tag, ".wdata_vec"}, wdata_vec, t.v);
        end
        chk({tag, ".retired"}, retired_count, exp_ret);
        chk({tag, ".timeout_err"}, timeout_err, exp_terr);
        $display("commit %s op=%0d mem=%0d rw=%0d rd=%0d delay=%0d retired=%0d", tag, t.op, t.mem, t.rw, t.rd, t.delay, exp_ret);
        exp_ret = (exp_ret + 1) % 65536;
    endtask

    task automatic run_one(input instr_t t, input string tag);
        bit to;
        int n;
        to = 0;
        drive(t);
        @(posedge clk); #1;
        if (t.mem && t.delay != 0) begin
            to = (t.delay > MEM_TIMEOUT);
            n  = to ? MEM_TIMEOUT : t.delay;
            for (int k = 1; k <= n; k++) begin
                valid_in  = 1'b1;
                op_type   = 1'($urandom);
                is_mem    = 1'($urandom);
                reg_write = 1'($urandom);
                rd        = 4'($urandom);
                if (!to && k == n) begin
                    mem_finished  = 1'b1;
                    scalar_output = t.s;
                    vector_output = t.v;
                end else begin
                    mem_finished  = 1'b0;
                    scalar_output = 8'($urandom);
                    vector_output = rand_vec();
                end
                @(negedge clk);
                chk({tag, ".wait_stall"}, stall, 1);
                chk({tag, ".wait_we_sca"}, we_sca, 0);
                chk({tag, ".wait_we_vec"}, we_vec, 0);
                chk({tag, ".wait_terr"}, timeout_err, exp_terr);
                @(posedge clk); #1;
            end
        end
        idle_inputs();
        @(negedge clk);
        if (to) begin
            exp_terr = 1;
            chk({tag, ".to_stall"}, stall, 0);
            chk({tag, ".to_we_sca"}, we_sca, 0);
            chk({tag, ".to_we_vec"}, we_vec, 0);
            chk({tag, ".to_terr"}, timeout_err, 1);
            chk({tag, ".to_retired"}, retired_count, exp_ret);
            $display("timeout %s rd=%0d retired=%0d", tag, t.rd, exp_ret);
        end else begin
            check_commit(t, tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input instr_t list[$], input string tag);
        for (int i = 0; i <= list.size(); i++) begin
            if (i < list.size()) drive(list[i]);
            else idle_inputs();
            @(negedge clk);
            if (i > 0) begin
                check_commit(list[i-1], tag);
            end else begin
                chk({tag, ".first_we_sca"}, we_sca, 0);
                chk({tag, ".first_we_vec"}, we_vec, 0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        instr_t t;
        instr_t q[$];

        // Reset with random inputs: every output must be zero.
        rst = 1'b1;
        idle_inputs();
        valid_in = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            valid_in = 1'($urandom);
            mem_finished = 1'($urandom);
        end
        @(negedge clk);
        chk("rst.stall", stall, 0);
        chk("rst.we_sca", we_sca, 0);
        chk("rst.we_vec", we_vec, 0);
        chk("rst.waddr_sca", waddr_sca, 0);
        chk("rst.wdata_sca", wdata_sca, 0);
        chk("rst.waddr_vec", waddr_vec, 0);
        chk("rst.wdata_vec", wdata_vec, 0);
        chk("rst.timeout_err", timeout_err, 0);
        chk("rst.retired", retired_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            chk("idle.stall", stall, 0);
            chk("idle.we_sca", we_sca, 0);
            chk("idle.we_vec", we_vec, 0);
            chk("idle.retired", retired_count, 0);
            @(posedge clk); #1;
            idle_inputs();
        end

        // Scalar ALU result to r3.
        t = mk(0, 0, 1, 4'd3, 0);
        t.s = 8'd40;
        run_one(t, "scalar_alu");

        // Vector load finishing after 20 wait cycles, lanes 100..119.
        t = mk(1, 1, 1, 4'd2, 20);
        for (int l = 0; l < LANES; l++) t.v[l] = 8'(100 + l);
        run_one(t, "vec_load");

        // Back-to-back scalars rd 1,2,0: the rd 0 write is suppressed but retires.
        q.delete();
        q.push_back(mk(0, 0, 1, 4'd1, 0));
        q.push_back(mk(0, 0, 1, 4'd2, 0));
        q.push_back(mk(0, 0, 1, 4'd0, 0));
        run_stream(q, "b2b");

        // Vector write to register 0 is allowed; store with no write still retires.
        run_one(mk(1, 0, 1, 4'd0, 0), "vec_rd0");
        run_one(mk(0, 1, 0, 4'd7, 3), "store");

        // Finish exactly on the last permitted cycle wins over timeout.
        run_one(mk(0, 1, 1, 4'd9, MEM_TIMEOUT), "finish_at_limit");
        run_one(mk(1, 1, 1, 4'd4, MEM_TIMEOUT - 1), "finish_before_limit");

        // Memory never finishes: timeout, no write, stage keeps working.
        run_one(mk(1, 1, 1, 4'd5, MEM_TIMEOUT + 10), "timeout");
        run_one(mk(0, 0, 1, 4'd6, 0), "after_timeout");

        // Randomized single instructions and streams.
        for (int i = 0; i < 40; i++) begin
            bit m;
            m = 1'($urandom);
            run_one(mk(1'($urandom), m, 1'($urandom), 4'($urandom), m ? int'($urandom_range(0, 8)) : 0), "rand");
        end
        for (int j = 0; j < 4; j++) begin
            q.delete();
            for (int i = 0; i < 6; i++) begin
                bit m;
                m = 1'($urandom);
                q.push_back(mk(1'($urandom), m, 1'($urandom), 4'($urandom), 0));
            end
            run_stream(q, "rand_stream");
        end

        // Reset in the middle of a vector load wait: no write, stall drops at once.
        t = mk(1, 1, 1, 4'd2, 20);
        drive(t);
        @(posedge clk); #1;
        valid_in = 1'b1;
        mem_finished = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_wait.stall_before", stall, 1);
        rst = 1'b1;
        #1;
        chk("mid_wait.stall_async", stall, 0);
        chk("mid_wait.terr_async", timeout_err, 0);
        exp_ret = 0;
        exp_terr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b0;
        mem_finished = 1'b1;
        scalar_output = t.s;
        vector_output = t.v;
        repeat (3) begin
            @(negedge clk);
            chk("mid_wait.we_vec", we_vec, 0);
            chk("mid_wait.we_sca", we_sca, 0);
            chk("mid_wait.stall", stall, 0);
            chk("mid_wait.retired", retired_count, 0);
            @(posedge clk); #1;
        end

        // Reset during the commit cycle aborts the write immediately.
        t = mk(0, 0, 1, 4'd5, 0);
        drive(t);
        @(posedge clk); #1;
        idle_inputs();
        chk("mid_commit.we_before", we_sca, 1);
        rst = 1'b1;
        #1;
        chk("mid_commit.we_async", we_sca, 0);
        chk("mid_commit.retired", retired_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_commit.we_after", we_sca, 0);
        chk("mid_commit.retired_after", retired_count, 0);
        @(posedge clk); #1;

        run_one(mk(1, 1, 1, 4'd8, 2), "post_reset");
        run_one(mk(0, 0, 1, 4'd1, 0), "post_reset2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
